and8_gate_feeder: RTL and testbench

//  Upstream stage for the 8-bit 3x1 AND gate. Buffers incoming bytes and drives the gate's three inputs:
//  out_byte -> in1, out_valid -> in2, out_en -> in3.
//  The gated result (byte & valid & en) is non-zero only inside a timed enable window.

---
 rtl/and8_feed_pkg.sv | 22 ++
 rtl/byte_fifo.sv | 75 +++++++
 rtl/and8_gate_feeder.sv | 121 ++++++++++++
 tb/tb_and8_gate_feeder.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/and8_feed_pkg.sv
// Shared definitions for the AND8 gate feeder: FSM state encoding, default
// sizing and the hold-counter width.
package and8_feed_pkg;

  // Output-stage states; the encoding is fixed so debug dumps read the same
  // across builds.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_HOLD  = 2'd2
  } feed_state_t;

  // Default FIFO depth (power of two, >= 2).
  localparam int DEFAULT_DEPTH = 4;

  // Default number of enable-high cycles per byte (1..15).
  localparam int DEFAULT_HOLD_CYCLES = 3;

  // Hold counter width, wide enough for HOLD_CYCLES up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/byte_fifo.sv
// DEPTH x 8 synchronous FIFO with registered full/empty flags and an
// occupancy count. Pushes while full and pops while empty are ignored.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [7:0]               din,
  output logic [7:0]               dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [7:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [LW-1:0] level_next_s;
  logic          full_r;
  logic          empty_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests against the registered flags and work out the next occupancy.
  always_comb begin
    do_push_s    = push & ~full_r;
    do_pop_s     = pop & ~empty_r;
    level_next_s = level_r;
    case ({do_push_s, do_pop_s})
      2'b10:   level_next_s = level_r + LW'(1);
      2'b01:   level_next_s = level_r - LW'(1);
      default: level_next_s = level_r;
    endcase
  end

  // Storage array; write-only on an accepted push, no reset needed for data.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and flags; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      level_r <= level_next_s;
      full_r  <= (level_next_s == LW'(DEPTH));
      empty_r <= (level_next_s == {LW{1'b0}});
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign level = level_r;

endmodule

// File: rtl/and8_gate_feeder.sv
// Upstream stage for the 8-bit 3-input AND gate. Buffers producer bytes in a
// small FIFO and presents each one to the gate as out_byte / out_valid /
// out_en, with out_en high for HOLD_CYCLES non-paused cycles per byte.
module and8_gate_feeder
  import and8_feed_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int HOLD_CYCLES = DEFAULT_HOLD_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   pause,
  output logic [7:0]             out_byte,
  output logic                   out_valid,
  output logic                   out_en,
  output logic [$clog2(DEPTH):0] level
);

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = 4'd1;

  feed_state_t      state_r;
  feed_state_t      state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic [7:0]       byte_r;
  logic [7:0]       byte_next_s;
  logic             valid_r;
  logic             valid_next_s;
  logic             hold_r;
  logic             pop_s;
  logic [7:0]       fifo_dout_s;
  logic             fifo_full_s;
  logic             fifo_empty_s;

  byte_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (pop_s),
    .din   (in_data),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (level)
  );

  // Next state, hold-counter update and FIFO pop decision for the output stage.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    byte_next_s  = byte_r;
    pop_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s        = 1'b1;
          byte_next_s  = fifo_dout_s;
          state_next_s = ST_SETUP;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_next_s = ST_HOLD;
        cnt_next_s   = HOLD_INIT;
      end
      ST_HOLD: begin
        if (pause) begin
          // Pause freezes the window; the counter only advances on enabled cycles.
          cnt_next_s = cnt_r;
        end else if (cnt_r <= CNT_ONE) begin
          // Last enabled cycle: chain straight into the next byte if one is queued.
          if (!fifo_empty_s) begin
            pop_s        = 1'b1;
            byte_next_s  = fifo_dout_s;
            state_next_s = ST_SETUP;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          cnt_next_s = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
    valid_next_s = (state_next_s != ST_IDLE);
  end

  // State, counter and output registers; reset drops the byte in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      byte_r  <= 8'h00;
      valid_r <= 1'b0;
      hold_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
      byte_r  <= byte_next_s;
      valid_r <= valid_next_s;
      hold_r  <= (state_next_s == ST_HOLD);
    end
  end

  // Pause must mask the enable in the very cycle it is asserted so the gate
  // output reads 00 for exactly the paused cycles; hence the late AND here.
  assign out_en    = hold_r & ~pause;
  assign out_byte  = byte_r;
  assign out_valid = valid_r;
  assign in_ready  = ~fifo_full_s;

endmodule

// File: tb/tb_and8_gate_feeder.sv
// Self-checking bench for and8_gate_feeder driving the 8-bit 3-input AND gate.
module tb_and8_gate_feeder;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;
  localparam int LW    = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          pause;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_en;
  logic [LW-1:0] level;
  logic [7:0]    gate_out;

  int n_checks;
  int n_fail;

  and8_gate_feeder #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .pause(pause), .out_byte(out_byte),
    .out_valid(out_valid), .out_en(out_en), .level(level)
  );

  // The downstream 8-bit 3-input AND gate.
  assign gate_out = out_byte & {8{out_valid}} & {8{out_en}};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hAA; pause = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if ({out_byte, out_valid, out_en, in_ready, level} !== {8'h00, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got byte=%h v=%b en=%b rdy=%b lvl=%0d, expected 00/0/0/1/0",
               out_byte, out_valid, out_en, in_ready, level);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    n_checks++;
    if ({out_valid, level} !== {1'b0, 3'd0}) begin
      n_fail++;
      $display("FAIL reset_nothing_stored: got v=%b lvl=%0d, expected 0/0", out_valid, level);
    end
    tick();
  endtask

  task automatic test_single_byte();
    logic [7:0] exp_gate;
    logic       exp_valid;
    int         en_cnt;
    en_cnt = 0;
    in_valid = 1'b1; in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      exp_gate  = (c >= 2 && c <= 4) ? 8'h33 : 8'h00;
      exp_valid = (c >= 1 && c <= 4);
      n_checks++;
      if (gate_out !== exp_gate || out_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL single_byte c=%0d: got gate=%h v=%b, expected gate=%h v=%b",
                 c, gate_out, out_valid, exp_gate, exp_valid);
      end
      if (out_en === 1'b1) en_cnt++;
      tick();
    end
    @(negedge clk);
    n_checks++;
    if (en_cnt != HOLD || out_byte !== 8'h33 || level !== 3'd0) begin
      n_fail++;
      $display("FAIL single_byte_window: got en_cycles=%0d byte=%h lvl=%0d, expected %0d/33/0",
               en_cnt, out_byte, level, HOLD);
    end
    tick();
  endtask

  task automatic test_fill();
    logic [7:0] fill_bytes [5];
    logic [7:0] got [$];
    logic       seen;
    logic       released;
    int         guard;
    fill_bytes = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    seen = 1'b0; released = 1'b0;
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = fill_bytes[i];
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL fill_ready_%0d: got in_ready=%b, expected 1", i, in_ready);
      end
      tick();
    end
    // Offer a stray byte while full; it must never be stored.
    in_data = 8'hEE;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({in_ready, level} !== {1'b0, 3'd4}) begin
        n_fail++;
        $display("FAIL fill_full_%0d: got rdy=%b lvl=%0d, expected 0/4", i, in_ready, level);
      end
      tick();
    end
    pause = 1'b0;
    guard = 0;
    while (guard < 200) begin
      @(negedge clk);
      if (!released && in_ready === 1'b1) begin
        released = 1'b1;
        in_valid = 1'b0;
        n_checks++;
        if (level !== 3'd3) begin
          n_fail++;
          $display("FAIL fill_no_bypass: got lvl=%0d after pop while full, expected 3", level);
        end
      end
      if (gate_out !== 8'h00 && !seen) begin
        got.push_back(gate_out);
        seen = 1'b1;
      end
      if (!out_valid || (!out_en && !pause)) seen = 1'b0;
      if (got.size() == 5 && out_valid === 1'b0) break;
      tick();
      guard++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (guard >= 200) begin
      n_fail++;
      $display("FAIL fill_timeout: got %0d windows within budget, expected 5", got.size());
    end
    n_checks++;
    if (got.size() != 5) begin
      n_fail++;
      $display("FAIL fill_window_count: got %0d, expected 5", got.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        n_checks++;
        if (got[i] !== fill_bytes[i]) begin
          n_fail++;
          $display("FAIL fill_order_%0d: got %h, expected %h", i, got[i], fill_bytes[i]);
        end
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_gate;
    logic       exp_valid;
    logic       exp_en;
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_data = 8'hC3;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp_valid = (c >= 1 && c <= 8);
      exp_en    = (c >= 2 && c <= 4) || (c >= 6 && c <= 8);
      exp_gate  = (c >= 2 && c <= 4) ? 8'h5A : ((c >= 6 && c <= 8) ? 8'hC3 : 8'h00);
      n_checks++;
      if ({out_valid, out_en, gate_out} !== {exp_valid, exp_en, exp_gate}) begin
        n_fail++;
        $display("FAIL back_to_back c=%0d: got v=%b en=%b gate=%h, expected v=%b en=%b gate=%h",
                 c, out_valid, out_en, gate_out, exp_valid, exp_en, exp_gate);
      end
      tick();
    end
  endtask

  task automatic test_pause();
    logic [7:0] exp_gate;
    logic       exp_valid;
    int         en_cnt;
    int         valid_cnt;
    en_cnt = 0; valid_cnt = 0;
    in_valid = 1'b1; in_data = 8'hF0;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      pause = (c == 3 || c == 4);
      @(negedge clk);
      exp_valid = (c >= 1 && c <= 6);
      exp_gate  = (c == 2 || c == 5 || c == 6) ? 8'hF0 : 8'h00;
      n_checks++;
      if (gate_out !== exp_gate || out_valid !== exp_valid) begin
        n_fail++;
        $display("FAIL pause c=%0d: got gate=%h v=%b, expected gate=%h v=%b",
                 c, gate_out, out_valid, exp_gate, exp_valid);
      end
      if (out_en === 1'b1) en_cnt++;
      if (out_valid === 1'b1) valid_cnt++;
      tick();
    end
    pause = 1'b0;
    n_checks++;
    if (en_cnt != HOLD || valid_cnt != HOLD + 3) begin
      n_fail++;
      $display("FAIL pause_window: got en_cycles=%0d valid_cycles=%0d, expected %0d/%0d",
               en_cnt, valid_cnt, HOLD, HOLD + 3);
    end
  endtask

  task automatic test_reset_mid_hold();
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    in_data = 8'h22;
    tick();
    in_data = 8'h33;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({level, out_en, out_byte} !== {3'd2, 1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL mid_hold_pre: got lvl=%0d en=%b byte=%h, expected 2/1/11", level, out_en, out_byte);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({out_byte, out_valid, out_en, in_ready, level} !== {8'h00, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      n_fail++;
      $display("FAIL mid_hold_reset: got byte=%h v=%b en=%b rdy=%b lvl=%0d, expected 00/0/0/1/0",
               out_byte, out_valid, out_en, in_ready, level);
    end
    for (int c = 0; c < 20; c++) begin
      tick();
      @(negedge clk);
      n_checks++;
      if ({out_valid, gate_out, level} !== {1'b0, 8'h00, 3'd0}) begin
        n_fail++;
        $display("FAIL mid_hold_flush c=%0d: got v=%b gate=%h lvl=%0d, expected 0/00/0",
                 c, out_valid, gate_out, level);
      end
    end
    tick();
  endtask

  task automatic test_random();
    logic [7:0] mq [$];
    logic       m_busy;
    logic       m_setup;
    int         m_left;
    logic [7:0] m_byte;
    logic       acc;
    logic       e_valid;
    logic       e_en;
    logic [7:0] e_gate;
    m_busy = 1'b0; m_setup = 1'b0; m_left = 0; m_byte = 8'h00;
    for (int i = 0; i < 800; i++) begin
      rst_n    = !(i < 2 || $urandom_range(0, 149) == 0);
      in_valid = ((i / 100) % 2 == 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      in_data  = 8'($urandom);
      pause    = ($urandom_range(0, 4) == 0);
      @(negedge clk);
      if (i > 0) begin
        e_valid = m_busy;
        e_en    = m_busy && !m_setup && !pause;
        e_gate  = e_en ? m_byte : 8'h00;
        n_checks++;
        if ({out_byte, out_valid, out_en, in_ready, level, gate_out} !==
            {m_byte, e_valid, e_en, (mq.size() < DEPTH), 3'(mq.size()), e_gate}) begin
          n_fail++;
          $display("FAIL random i=%0d: got byte=%h v=%b en=%b rdy=%b lvl=%0d gate=%h, expected byte=%h v=%b en=%b rdy=%b lvl=%0d gate=%h",
                   i, out_byte, out_valid, out_en, in_ready, level, gate_out,
                   m_byte, e_valid, e_en, (mq.size() < DEPTH), mq.size(), e_gate);
        end
      end
      tick();
      // Reference model: FIFO as a queue, output stage as setup + HOLD enabled cycles.
      if (!rst_n) begin
        mq.delete();
        m_busy = 1'b0; m_setup = 1'b0; m_left = 0; m_byte = 8'h00;
      end else begin
        acc = in_valid && (mq.size() < DEPTH);
        if (!m_busy) begin
          if (mq.size() > 0) begin
            m_byte = mq.pop_front(); m_busy = 1'b1; m_setup = 1'b1;
          end
        end else if (m_setup) begin
          m_setup = 1'b0; m_left = HOLD;
        end else if (!pause) begin
          m_left--;
          if (m_left == 0) begin
            if (mq.size() > 0) begin
              m_byte = mq.pop_front(); m_setup = 1'b1;
            end else begin
              m_busy = 1'b0;
            end
          end
        end
        if (acc) mq.push_back(in_data);
      end
    end
    rst_n = 1'b1; in_valid = 1'b0; pause = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "bench time limit");
  end

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; pause = 1'b0;
    test_reset();
    test_single_byte();
    test_fill();
    test_back_to_back();
    test_pause();
    test_reset_mid_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
